// File: rtl/daq_frame_sequencer.sv
// daq_frame_sequencer: paces SPI DAQ frames at a programmable sample period,
// rotates the ADC channel address across an enable mask, re-associates each
// returned ADC word with the channel that produced it one frame earlier, and
// flags overruns when a period tick lands on a frame still in progress.
module daq_frame_sequencer #(
    parameter int unsigned DIVW = 16,
    parameter int unsigned NCH  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [DIVW-1:0] period,
    input  logic [NCH-1:0]  chmask,
    input  logic            frame_done,
    input  logic [11:0]     adc_data,
    input  logic            clear_overrun,
    output logic            frame_start,
    output logic [2:0]      adc_channel,
    output logic            dac_load,
    output logic            sample_valid,
    output logic [2:0]      sample_chan,
    output logic [11:0]     sample_data,
    output logic            busy,
    output logic            overrun
);

    // Index width used to address individual chmask bits.
    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy,
        StCapture
    } state_e;

    state_e          state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic            tick;
    logic [2:0]      adc_channel_q;
    logic [2:0]      prev_chan_q;
    logic            prime_q;
    logic [2:0]      sample_chan_q;
    logic [11:0]     sample_data_q;
    logic            overrun_q;

    logic [2:0]      lowest_chan;
    logic [2:0]      next_chan;
    logic [2:0]      chan_sel;
    int              pos;

    logic            load_chan;
    logic            capture;
    logic            close_frame;
    logic            prime_clr;
    logic            overrun_set;

    // Period counter: counts 0..period while enabled, held at 0 otherwise.
    always_comb begin
        tick  = 1'b0;
        cnt_d = '0;
        if (enable) begin
            tick  = (cnt_q == period);
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Channel pick: lowest set bit for an unprimed start, otherwise the next
    // set bit strictly after the current address, wrapping NCH-1 -> 0.
    always_comb begin
        lowest_chan = '0;
        next_chan   = adc_channel_q;
        pos         = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chmask[IW'(i)]) begin
                lowest_chan = 3'(i);
            end
        end
        // Descending search so the smallest forward distance wins.
        for (int k = NCH; k >= 1; k--) begin
            pos = int'(adc_channel_q) + k;
            if (pos >= int'(NCH)) begin
                pos = pos - int'(NCH);
            end
            if (chmask[IW'(pos)]) begin
                next_chan = 3'(pos);
            end
        end
        chan_sel = prime_q ? next_chan : lowest_chan;
    end

    // Frame FSM next-state and decoded outputs.
    always_comb begin
        state_d      = state_q;
        frame_start  = 1'b0;
        dac_load     = 1'b0;
        busy         = 1'b0;
        sample_valid = 1'b0;
        load_chan    = 1'b0;
        capture      = 1'b0;
        close_frame  = 1'b0;
        prime_clr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Leaving enable low while idle restarts the ADC pipeline.
                if (!enable) begin
                    prime_clr = 1'b1;
                end
                if (tick && (chmask != '0)) begin
                    load_chan = 1'b1;
                    state_d   = StStart;
                end
            end
            StStart: begin
                frame_start = 1'b1;
                dac_load    = 1'b1;
                state_d     = StBusy;
            end
            StBusy: begin
                busy = 1'b1;
                if (frame_done) begin
                    capture = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // The first frame of a run only primes the ADC pipeline.
                sample_valid = prime_q;
                close_frame  = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        overrun_set = tick && (state_q != StIdle);
    end

    // FSM state and period counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Channel address, pipeline bookkeeping and captured sample registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_channel_q <= '0;
            prev_chan_q   <= '0;
            prime_q       <= 1'b0;
            sample_chan_q <= '0;
            sample_data_q <= '0;
        end else begin
            if (load_chan) begin
                adc_channel_q <= chan_sel;
            end
            // Data shifted in this frame belongs to the previous frame's address.
            if (capture) begin
                sample_data_q <= adc_data;
                sample_chan_q <= prev_chan_q;
            end
            if (close_frame) begin
                prev_chan_q <= adc_channel_q;
                prime_q     <= 1'b1;
            end else if (prime_clr) begin
                prime_q <= 1'b0;
            end
        end
    end

    // Sticky overrun; a coincident set beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (overrun_set) begin
            overrun_q <= 1'b1;
        end else if (clear_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign adc_channel = adc_channel_q;
    assign sample_chan = sample_chan_q;
    assign sample_data = sample_data_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_daq_frame_sequencer.sv
// Randomized bench for daq_frame_sequencer with a cycle-numbered reference
// model; the bench also plays the SPI master returning frame_done pulses.
module tb_daq_frame_sequencer;

    localparam int unsigned DIVW = 16;
    localparam int unsigned NCH  = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [DIVW-1:0] period;
    logic [NCH-1:0]  chmask;
    logic            frame_done;
    logic [11:0]     adc_data;
    logic            clear_overrun;
    logic            frame_start;
    logic [2:0]      adc_channel;
    logic            dac_load;
    logic            sample_valid;
    logic [2:0]      sample_chan;
    logic [11:0]     sample_data;
    logic            busy;
    logic            overrun;

    always #5 clk = ~clk;

    daq_frame_sequencer #(
        .DIVW(DIVW),
        .NCH (NCH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .period       (period),
        .chmask       (chmask),
        .frame_done   (frame_done),
        .adc_data     (adc_data),
        .clear_overrun(clear_overrun),
        .frame_start  (frame_start),
        .adc_channel  (adc_channel),
        .dac_load     (dac_load),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: frames are described by the cycle numbers of their
    // start and of the frame_done that ended them.
    int cyc;
    int en_cycles;
    bit m_open;
    int m_start;
    int m_done;
    bit m_primed;
    int m_cur;
    int m_prev;
    bit m_vflag;
    int m_schan;
    int m_sdata;
    bit m_ovr;

    // SPI master emulation and bookkeeping.
    int flen;
    int fd_timer;
    bit spur;
    int clr_rate;
    int starts_seen;
    int valids_seen;
    bit saw_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int mask, input bit have_prev, input int prevc);
        int c;
        pick = 0;
        if (!have_prev) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (((mask >> i) & 1) == 1) pick = i;
            end
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                c = (prevc + k) % NCH;
                if (((mask >> c) & 1) == 1) pick = c;
            end
        end
    endfunction

    task automatic model_reset();
        en_cycles = 0;
        m_open    = 1'b0;
        m_start   = -10;
        m_done    = -1;
        m_primed  = 1'b0;
        m_cur     = 0;
        m_prev    = 0;
        m_vflag   = 1'b0;
        m_schan   = 0;
        m_sdata   = 0;
        m_ovr     = 1'b0;
    endtask

    // Advance the model across one clock edge; cyc is the cycle that just ended.
    task automatic model_step();
        bit t;
        bit was_open;
        t = enable && ((en_cycles % (int'(period) + 1)) == int'(period));
        en_cycles = enable ? en_cycles + 1 : 0;
        was_open = m_open;
        if (was_open) begin
            if (m_done < 0 && cyc > m_start && frame_done) begin
                m_done  = cyc;
                m_vflag = m_primed;
                m_schan = m_prev;
                m_sdata = int'(adc_data);
            end else if (m_done >= 0 && cyc == m_done + 1) begin
                m_open   = 1'b0;
                m_prev   = m_cur;
                m_primed = 1'b1;
            end
        end else begin
            if (!enable) begin
                m_primed = 1'b0;
            end else if (t && chmask != '0) begin
                m_cur   = pick(int'(chmask), m_primed, m_cur);
                m_open  = 1'b1;
                m_start = cyc + 1;
                m_done  = -1;
            end
        end
        if (t && was_open) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
        cyc++;
    endtask

    task automatic compare_all();
        bit e_start;
        bit e_busy;
        bit e_valid;
        e_start = m_open && (cyc == m_start);
        e_busy  = m_open && (cyc > m_start) && (m_done < 0);
        e_valid = m_open && (m_done >= 0) && (cyc == m_done + 1) && m_vflag;
        check("frame_start", 32'(frame_start), 32'(e_start));
        check("dac_load", 32'(dac_load), 32'(e_start));
        check("busy", 32'(busy), 32'(e_busy));
        check("sample_valid", 32'(sample_valid), 32'(e_valid));
        check("adc_channel", 32'(adc_channel), 32'(m_cur));
        check("sample_chan", 32'(sample_chan), 32'(m_schan));
        check("sample_data", 32'(sample_data), 32'(m_sdata));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // One clock: model at the edge, compare at the falling edge, then drive.
    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        compare_all();
        saw_start = frame_start;
        if (frame_start) starts_seen++;
        if (sample_valid) valids_seen++;
        frame_done = 1'b0;
        if (frame_start) begin
            fd_timer = flen;
        end else if (fd_timer > 0) begin
            fd_timer--;
            if (fd_timer == 0) frame_done = 1'b1;
        end else if (spur && $urandom_range(0, 15) == 0) begin
            frame_done = 1'b1;
        end
        adc_data      = 12'($urandom);
        clear_overrun = (clr_rate != 0) && ($urandom_range(0, clr_rate - 1) == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_cfg(input int p, input int m, input int l);
        enable = 1'b0;
        run(3);
        period = DIVW'(p);
        chmask = NCH'(m);
        flen   = l;
        enable = 1'b1;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int w;
        w = 0;
        saw_start = 1'b0;
        while (!saw_start && w < budget) begin
            cycle();
            w++;
        end
        check(tag, 32'(saw_start), 32'd1);
    endtask

    initial begin
        int s0;
        int v0;
        int w;
        reset_n       = 1'b0;
        enable        = 1'b0;
        period        = '0;
        chmask        = '0;
        frame_done    = 1'b0;
        adc_data      = '0;
        clear_overrun = 1'b0;
        cyc           = 0;
        flen          = 10;
        fd_timer      = 0;
        spur          = 1'b0;
        clr_rate      = 0;
        starts_seen   = 0;
        valids_seen   = 0;
        saw_start     = 1'b0;
        model_reset();
        run(3);
        reset_n = 1'b1;

        // Nominal pacing: channels 0,2 alternate.
        set_cfg(99, 8'h05, 40);
        s0 = starts_seen;
        run(420);
        check("starts_p99", 32'(starts_seen - s0), 32'd4);

        // Single channel 7, then wrap to 0 without dropping enable.
        set_cfg(49, 8'h80, 20);
        spur = 1'b1;
        run(200);
        chmask = 8'h81;
        run(160);

        // Overrun: frames longer than the period; clears race the ticks.
        set_cfg(19, 8'h3c, 30);
        clr_rate = 3;
        s0 = starts_seen;
        run(400);
        check("starts_overrun", 32'(starts_seen - s0), 32'd10);
        clr_rate = 0;

        // Empty mask never issues a frame.
        set_cfg(7, 8'h00, 5);
        s0 = starts_seen;
        run(1000);
        check("starts_mask0", 32'(starts_seen - s0), 32'd0);

        // Drop enable five cycles into a primed frame.
        set_cfg(59, 8'h92, 20);
        run(200);
        wait_start("wait_start_drop", 200);
        v0 = valids_seen;
        run(5);
        enable = 1'b0;
        s0 = starts_seen;
        run(150);
        check("drop_valid", 32'(valids_seen - v0), 32'd1);
        check("drop_no_start", 32'(starts_seen - s0), 32'd0);
        enable = 1'b1;
        run(200);

        // Randomized configurations with occasional enable blips.
        clr_rate = 8;
        for (int r = 0; r < 8; r++) begin
            set_cfg($urandom_range(8, 60), $urandom_range(0, 255), $urandom_range(1, 70));
            for (int i = 0; i < 300; i++) begin
                cycle();
                if ($urandom_range(0, 99) == 0) enable = ~enable;
            end
        end
        clr_rate = 0;

        // Asynchronous reset while a frame is in BUSY.
        set_cfg(39, 8'h44, 25);
        w = 0;
        while (busy !== 1'b1 && w < 200) begin
            cycle();
            w++;
        end
        check("wait_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_dac_load", 32'(dac_load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_adc_channel", 32'(adc_channel), 32'd0);
        check("rst_sample_chan", 32'(sample_chan), 32'd0);
        check("rst_sample_data", 32'(sample_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        model_reset();
        fd_timer = 0;
        run(2);
        reset_n = 1'b1;
        v0 = valids_seen;
        wait_start("wait_start_post_rst", 100);
        check("post_rst_chan", 32'(adc_channel), 32'd2);
        run(45);
        check("post_rst_no_valid", 32'(valids_seen - v0), 32'd0);
        run(150);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/daq_frame_sequencer.md
# daq_frame_sequencer

Frame scheduler for the shared SPI DAQ bus. It paces SPI frames at a programmable sample period and issues one-cycle start pulses to the SPI master controller. Each frame it steps the ADC channel address round-robin across an enable mask. It re-associates each returned ADC result with the channel that produced it, which the ADC pipelines by one frame, and flags overruns when a period expires with a frame still running. It sits between the SPI master controller and the ADC/DAC frame engines, in the same divided-clock domain.

## Interface
- `DIVW`, 16: width of the sample-period counter.
- `NCH`, 8: number of channels; `chmask` width; max 8 (channel field is 3 bits).
- `clk` in 1: divided DAQ clock (same clock as the SPI master controller).
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run frames when high.
- `period` in DIVW: frame period in `clk` cycles minus 1.
- `chmask` in NCH: bit i set = channel i in the rotation.
- `frame_done` in 1: one-cycle end-of-frame pulse from the SPI master controller.
- `adc_data` in 12: ADC result shifted in during the frame just ended.
- `frame_start` out 1: one-cycle pulse, begin SPI frame.
- `adc_channel` out 3: channel address driven on ADC MOSI this frame.
- `dac_load` out 1: one-cycle pulse coincident with `frame_start`; DAC data sources latch their next word.
- `sample_valid` out 1: one-cycle pulse, `sample_chan`/`sample_data` valid.
- `sample_chan` out 3: channel that produced `sample_data`.
- `sample_data` out 12: captured ADC word.
- `busy` out 1: frame in progress.
- `overrun` out 1: sticky, a period tick found a frame in progress.
- `clear_overrun` in 1: synchronous clear of `overrun`.

## Operation
- Reset (`reset_n` low, async): all outputs 0, period counter 0, state IDLE, `adc_channel`=0, prime flag clear, previous-channel register 0.
- Period counter: free-runs while `enable`. Counts 0..`period`, then wraps. A tick occurs on the cycle count==`period`, so ticks are `period`+1 cycles apart. The counter is held at 0 when `enable` is low.
- State machine:
  - IDLE: on tick with `chmask`≠0 → START. Ticks with `chmask`==0 are ignored and no frame is issued.
  - START (1 cycle): `frame_start`=`dac_load`=1. `adc_channel` is loaded with the next set bit of `chmask` strictly after the previous channel, wrapping NCH-1→0. The first frame after reset or enable takes the lowest set bit. → BUSY.
  - BUSY: `busy`=1. Wait for `frame_done`, then → CAPTURE.
  - CAPTURE (1 cycle): `sample_data`←`adc_data` as registered at `frame_done`. `sample_chan`← previous-frame channel. `sample_valid`=1 only if the prime flag is set. Then previous-channel ← `adc_channel` and prime flag ← 1. → IDLE.
- One-frame pipeline: the ADC returns the conversion for the address sent in the preceding frame. The first frame after reset or after `enable` rises returns no valid sample.
- Tick while in START, BUSY or CAPTURE: the tick is dropped and `overrun`←1.
- `overrun` stays set until `clear_overrun`. If a tick sets `overrun` in the same cycle as `clear_overrun`, set wins.
- `enable` falling mid-frame: the current frame completes and is captured normally. Then the block stays in IDLE and the prime flag clears.
- `chmask` changes take effect at the next START. `adc_channel` is stable from START until the next START.
- `frame_done` outside BUSY is ignored.

## Timing
- Tick at cycle T → `frame_start`, `dac_load` and the new `adc_channel` all registered high/valid at T+1, for exactly 1 cycle.
- `frame_done` at cycle D → `sample_valid` and the captured data at D+1. Next START no earlier than the next tick.
- `sample_chan`/`sample_data` hold their value until the next CAPTURE.
- Throughput: one frame per tick, provided the frame length + 2 ≤ `period`+1.

## Test plan
- Reset mid-BUSY (assert `reset_n`=0) → all outputs 0 immediately and asynchronously. After release, the first tick addresses the lowest mask bit and `sample_valid` stays low for that frame.
- `period`=99, `chmask`=8'b0000_0101, frame length 40 → `frame_start` every 100 cycles. `adc_channel` sequence 0,2,0,2. `sample_chan` sequence 0,2,0 starting at the second frame. `sample_data` equals the `adc_data` presented at the matching `frame_done`.
- `chmask`=8'h80 → every frame addresses 7. Then `chmask`=8'h81 → next frame addresses 0 (wrap from 7).
- `period`=19, frame length 30 → `overrun`=1 on the first dropped tick. A frame is issued every 40 cycles. `clear_overrun` coincident with a dropped tick → `overrun` remains 1.
- `chmask`=0 with `enable`=1 for 1000 cycles → no `frame_start`, `busy`=0.
- `enable` dropped 5 cycles into a frame → that frame's `sample_valid` still fires and no further `frame_start` follows. After re-enable, the first frame produces no `sample_valid`.
